// File: rtl/wb_arbiter_pkg.sv
// Shared CPU definitions for the writeback path:
// data width, register address width and channel encoding.
package wb_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  localparam int CH_LD  = 0;
  localparam int CH_ALU = 1;

  typedef logic [RAW-1:0] reg_addr_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; priority flips only
// when both requests were present and the enable is high.
module rr_arb2
  import wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic r_prio;
  logic w_both;

  assign w_both = &i_req;

  always_comb begin
    o_gnt = i_req;
    if (w_both) begin
      o_gnt = r_prio ? 2'b10 : 2'b01;
    end
  end

  // r_prio holds the index of the channel favoured next contention
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio <= 1'(CH_LD);
    end else if (i_en && w_both) begin
      r_prio <= ~r_prio;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto one
// register-file write port and tracks outstanding writes.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN = wb_arbiter_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [RAW-1:0]  alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [RAW-1:0]  ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  input  logic            iss_valid,
  input  logic [RAW-1:0]  iss_rd,
  output logic [NREG-1:0] pending,
  output logic            rf_we,
  output logic [RAW-1:0]  rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic [31:0]     wb_count
);

  logic [1:0]      w_req;
  logic [1:0]      w_gnt;
  logic            w_take;
  logic            w_commit;
  logic [RAW-1:0]  w_rd;
  logic [XLEN-1:0] w_wd;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_pend_nxt;

  logic            r_rf_we;
  logic [RAW-1:0]  r_rf_wa;
  logic [XLEN-1:0] r_rf_wd;
  logic [NREG-1:0] r_pending;
  logic [31:0]     r_wb_count;

  // requests are masked in reset so no grant can leak out
  assign w_req[CH_LD]  = ld_valid  & rst_n;
  assign w_req[CH_ALU] = alu_valid & rst_n;

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (w_req),
    .i_en  (w_take),
    .o_gnt (w_gnt)
  );

  assign ld_ready  = w_gnt[CH_LD];
  assign alu_ready = w_gnt[CH_ALU];

  assign w_take   = |w_gnt;
  assign w_rd     = w_gnt[CH_ALU] ? alu_rd : ld_rd;
  assign w_wd     = w_gnt[CH_ALU] ? alu_data : ld_data;
  assign w_commit = w_take && (w_rd != '0);

  always_comb begin
    w_clr = '0;
    w_set = '0;
    if (w_commit) begin
      w_clr = NREG'(1) << w_rd;
    end
    if (iss_valid && (iss_rd != '0)) begin
      w_set = NREG'(1) << iss_rd;
    end
    // set applied after clear so a same-cycle reissue wins
    w_pend_nxt    = (r_pending & ~w_clr) | w_set;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_wa    <= '0;
      r_rf_wd    <= '0;
      r_pending  <= '0;
      r_wb_count <= '0;
    end else begin
      r_rf_we   <= w_commit;
      r_pending <= w_pend_nxt;
      if (w_commit) begin
        r_rf_wa    <= w_rd;
        r_rf_wd    <= w_wd;
        r_wb_count <= r_wb_count + 32'd1;
      end
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_wa    = r_rf_wa;
  assign rf_wd    = r_rf_wd;
  assign pending  = r_pending;
  assign wb_count = r_wb_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal
// expectations plus a per-cycle comparison against a model.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, ld_valid, iss_valid;
  logic [4:0]  alu_rd, ld_rd, iss_rd;
  logic [31:0] alu_data, ld_data;
  logic        alu_ready, ld_ready;
  logic [31:0] pending;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] wb_count;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .pending   (pending),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .wb_count  (wb_count)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_ld_turn;
  bit [31:0]   m_cnt;
  bit [31:0]   m_pend;
  bit          m_we;
  bit [4:0]    m_wa;
  bit [31:0]   m_wd;

  // returns {alu_granted, ld_granted}
  function automatic bit [1:0] exp_gnt();
    if (rst_n !== 1'b1) return 2'b00;
    if (alu_valid && ld_valid) return m_ld_turn ? 2'b01 : 2'b10;
    return {alu_valid, ld_valid};
  endfunction

  always @(posedge clk) begin
    bit [1:0]  g;
    bit [4:0]  rd;
    bit [31:0] d;
    g = exp_gnt();
    if (rst_n !== 1'b1) begin
      m_ld_turn = 1'b1;
      m_cnt = 0; m_pend = 0;
      m_we = 0; m_wa = 0; m_wd = 0;
    end else begin
      m_we = 1'b0;
      if (g != 2'b00) begin
        rd = g[1] ? alu_rd : ld_rd;
        d  = g[1] ? alu_data : ld_data;
        if (alu_valid && ld_valid) m_ld_turn = g[1];
        if (rd != 0) begin
          m_we = 1'b1;
          m_wa = rd;
          m_wd = d;
          m_cnt = m_cnt + 1;
          m_pend[rd] = 1'b0;
        end
      end
      if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    bit [1:0] g;
    if (chk_on) begin
      g = exp_gnt();
      chk("cmp ld_ready", ld_ready, g[0]);
      chk("cmp alu_ready", alu_ready, g[1]);
      chk("cmp rf_we", rf_we, m_we);
      chk("cmp rf_wa", rf_wa, m_wa);
      chk("cmp rf_wd", rf_wd, m_wd);
      chk("cmp pending", pending, m_pend);
      chk("cmp wb_count", wb_count, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    iss_valid = 0; iss_rd = 0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1; alu_rd = rd; alu_data = d;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [31:0] d);
    ld_valid = 1; ld_rd = rd; ld_data = d;
  endtask

  task automatic iss(input logic [4:0] rd);
    iss_valid = 1; iss_rd = rd;
  endtask

  logic [4:0] exp_wa [4] = '{5'd3, 5'd4, 5'd3, 5'd4};
  logic       exp_ld [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    idle();
    alu(5'd2, 32'h1); ld(5'd3, 32'h2);
    cyc();
    chk_on = 1'b1;
    chk("rst alu_ready", alu_ready, 1'b0);
    chk("rst ld_ready", ld_ready, 1'b0);
    cyc();
    chk("rst rf_we", rf_we, 1'b0);
    chk("rst pending", pending, 32'h0);
    chk("rst wb_count", wb_count, 32'h0);
    idle();
    rst_n = 1'b1;
    cyc();

    // single ALU write
    alu(5'd5, 32'hDEADBEEF);
    #1 chk("single alu_ready", alu_ready, 1'b1);
    cyc();
    chk("single rf_we", rf_we, 1'b1);
    chk("single rf_wa", rf_wa, 5'd5);
    chk("single rf_wd", rf_wd, 32'hDEADBEEF);
    chk("single wb_count", wb_count, 32'd1);
    idle();
    cyc();
    chk("idle rf_we", rf_we, 1'b0);
    chk("idle rf_wa hold", rf_wa, 5'd5);

    // contention: LD, ALU, LD, ALU
    ld(5'd3, 32'h33); alu(5'd4, 32'h44);
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr ld_ready", ld_ready, exp_ld[i]);
      cyc();
      chk("rr rf_wa", rf_wa, exp_wa[i]);
    end
    idle();
    cyc();
    chk("rr wb_count", wb_count, 32'd5);

    // scoreboard set, hold, clear
    iss(5'd7);
    cyc();
    chk("sb set", pending[7], 1'b1);
    idle();
    cyc();
    chk("sb hold1", pending[7], 1'b1);
    cyc();
    chk("sb hold2", pending[7], 1'b1);
    alu(5'd7, 32'h77);
    cyc();
    chk("sb clear", pending[7], 1'b0);
    iss(5'd7);
    cyc();
    chk("sb set wins", pending[7], 1'b1);
    chk("sb set wins we", rf_we, 1'b1);
    idle();
    alu(5'd7, 32'h78);
    cyc();
    chk("sb clear2", pending, 32'h0);

    // x0 load plus x0 issue
    idle();
    ld(5'd0, 32'h1234); iss(5'd0);
    #1 chk("x0 ld_ready", ld_ready, 1'b1);
    cyc();
    chk("x0 rf_we", rf_we, 1'b0);
    chk("x0 pending", pending, 32'h0);
    chk("x0 wb_count", wb_count, 32'd8);
    idle();
    cyc();

    // reset mid-operation
    ld(5'd9, 32'h99); alu(5'd10, 32'hAA);
    cyc();
    rst_n = 1'b0;
    #1 chk("mid rst alu_ready", alu_ready, 1'b0);
    cyc();
    chk("mid rst rf_we", rf_we, 1'b0);
    chk("mid rst rf_wa", rf_wa, 5'd0);
    chk("mid rst rf_wd", rf_wd, 32'h0);
    chk("mid rst wb_count", wb_count, 32'h0);
    rst_n = 1'b1;
    idle();
    cyc();
    chk("post rst rf_we", rf_we, 1'b0);
    ld(5'd9, 32'h99); alu(5'd10, 32'hAA);
    #1 chk("post rst ld first", ld_ready, 1'b1);
    cyc();
    chk("post rst rf_wa", rf_wa, 5'd9);
    idle();
    cyc();

    // counter wrap
    force dut.r_wb_count = 32'hFFFFFFFF;
    m_cnt = 32'hFFFFFFFF;
    alu(5'd1, 32'h1);
    #5;
    release dut.r_wb_count;
    cyc();
    chk("wrap wb_count", wb_count, 32'h0);
    chk("wrap rf_wa", rf_wa, 5'd1);
    idle();
    cyc();
    cyc();

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
